// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and types for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  localparam int          PC_W        = 8;
  localparam int          INSTR_W     = 16;
  localparam logic [7:0]  RESET_PC    = 8'h00;
  localparam logic [3:0]  HALT_OPCODE = 4'hF;

  // Opcode field position inside an instruction word
  localparam int          OPC_HI      = 15;
  localparam int          OPC_LO      = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // True when the word carries the HALT opcode
  function automatic logic is_halt(input logic [INSTR_W-1:0] w);
    return w[OPC_HI:OPC_LO] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns pc, captures memory words into ir, and hands
// them to decode over valid/ready. Handles redirect, stall and HALT.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    pc_out,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  fetch_state_e       state, state_n;
  logic [PC_W-1:0]    pc, pc_n;
  logic [INSTR_W-1:0] ir_n;
  logic [PC_W-1:0]    ir_pc_n;
  logic               ir_valid_n;
  logic [15:0]        fetch_count_n;
  logic               slot_free;

  // Memory reads are asynchronous, so the pc register addresses it directly
  assign pc_out    = pc;
  assign halted    = (state == ST_HALT);
  assign slot_free = !ir_valid || ir_ready;

  // Register all fetch state; rst wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      ir          <= ir_n;
      ir_pc       <= ir_pc_n;
      ir_valid    <= ir_valid_n;
      fetch_count <= fetch_count_n;
    end
  end

  // Next-state: redirect beats capture, capture only into a free slot
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    ir_n          = ir;
    ir_pc_n       = ir_pc;
    ir_valid_n    = ir_valid;
    fetch_count_n = fetch_count;
    unique case (state)
      ST_IDLE: begin
        if (start) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          // Flush: the word on mem_instr belongs to the wrong path
          pc_n       = redirect_pc;
          ir_valid_n = 1'b0;
        end else if (slot_free) begin
          ir_n       = mem_instr;
          ir_pc_n    = pc;
          ir_valid_n = 1'b1;
          if (fetch_count != 16'hFFFF) fetch_count_n = fetch_count + 16'd1;
          if (is_halt(mem_instr)) state_n = ST_HALT;
          else                    pc_n    = pc + 1'b1;
        end
      end
      ST_HALT: begin
        if (start) begin
          pc_n       = RESET_PC;
          ir_valid_n = 1'b0;
          state_n    = ST_RUN;
        end else if (ir_valid && ir_ready) begin
          // HALT word drains to decode, then the slot empties
          ir_valid_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: expected (ir_pc, ir) pairs queued as stimulus is set
// up, popped whenever decode accepts a word.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic               clk = 1'b0;
  logic               rst, start, redirect_valid, ir_ready;
  logic [PC_W-1:0]    pc_out, redirect_pc, ir_pc;
  logic [INSTR_W-1:0] mem_instr, ir;
  logic               ir_valid, halted;
  logic [15:0]        fetch_count;

  logic [INSTR_W-1:0] mem [256];
  logic [23:0]        sb_q [$];
  int                 n_chk = 0;
  int                 n_fail = 0;

  always #5 clk = ~clk;
  assign mem_instr = mem[pc_out];

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .pc_out(pc_out),
    .mem_instr(mem_instr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .halted(halted),
    .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [15:0] w);
    sb_q.push_back({a, w});
  endtask

  // Decode side: every accepted word must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && ir_valid && ir_ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected", {8'h0, ir_pc, ir}, 32'hFFFF_FFFF);
      else begin
        logic [23:0] e;
        e = sb_q.pop_front();
        chk("sb_ir_pc", ir_pc, e[23:16]);
        chk("sb_ir", ir, e[15:0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    rst = 1; start = 0; redirect_valid = 0; redirect_pc = '0; ir_ready = 1;
    step(2);
    chk("rst_pc", pc_out, RESET_PC);
    chk("rst_vld", ir_valid, 0);
    chk("rst_ir", ir, 0);
    chk("rst_irpc", ir_pc, 0);
    chk("rst_halt", halted, 0);
    chk("rst_cnt", fetch_count, 0);
    rst = 0;
    step;
    chk("idle_vld", ir_valid, 0);
    chk("idle_pc", pc_out, 0);

    // Straight-line run 0..3
    start = 1;
    step;
    start = 0;
    chk("run_pc0", pc_out, 0);
    chk("run_vld0", ir_valid, 0);
    for (int i = 0; i < 4; i++) push(8'(i), 16'h1000 | 16'(i));
    step;
    chk("lat_ir", ir, 16'h1000);
    chk("lat_pc", pc_out, 1);
    step(3);
    ir_ready = 0;
    chk("seq_ir", ir, 16'h1003);
    chk("seq_irpc", ir_pc, 3);
    chk("seq_cnt", fetch_count, 4);

    // Back-pressure stall
    for (int i = 0; i < 3; i++) begin
      step;
      chk("stall_ir", ir, 16'h1003);
      chk("stall_irpc", ir_pc, 3);
      chk("stall_pc", pc_out, 4);
      chk("stall_cnt", fetch_count, 4);
      chk("stall_vld", ir_valid, 1);
    end
    push(4, 16'h1004);
    ir_ready = 1;
    step;
    chk("rel_ir", ir, 16'h1004);
    chk("rel_cnt", fetch_count, 5);

    // Redirect to 0x40; 0x1004 still accepted on the flush cycle
    redirect_valid = 1; redirect_pc = 8'h40;
    step;
    redirect_valid = 0;
    chk("redir_vld", ir_valid, 0);
    chk("redir_pc", pc_out, 8'h40);
    chk("redir_cnt", fetch_count, 5);
    push(8'h40, 16'h1040);
    step;
    chk("redir_ir", ir, 16'h1040);
    chk("redir_irpc", ir_pc, 8'h40);
    chk("redir_pc2", pc_out, 8'h41);

    // HALT word at 5
    mem[5] = 16'hF000;
    redirect_valid = 1; redirect_pc = 8'h03;
    step;
    redirect_valid = 0;
    push(3, 16'h1003); push(4, 16'h1004); push(5, 16'hF000);
    step(3);
    ir_ready = 0;
    chk("halt_ir", ir, 16'hF000);
    chk("halt_irpc", ir_pc, 5);
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc_out, 5);
    chk("halt_cnt", fetch_count, 9);
    step;
    chk("halt_hold_vld", ir_valid, 1);
    ir_ready = 1;
    step;
    chk("halt_drain_vld", ir_valid, 0);
    redirect_valid = 1; redirect_pc = 8'h80;
    step(2);
    redirect_valid = 0;
    chk("halt_redir_pc", pc_out, 5);
    chk("halt_nocap", fetch_count, 9);
    chk("halt_still", halted, 1);

    // Restart
    mem[5] = 16'h1005;
    start = 1;
    step;
    start = 0;
    chk("rs_pc", pc_out, RESET_PC);
    chk("rs_halt", halted, 0);
    chk("rs_cnt", fetch_count, 9);
    push(0, 16'h1000);
    step;
    chk("rs_ir", ir, 16'h1000);
    chk("rs_cnt2", fetch_count, 10);

    // Address wrap FE, FF, 00
    redirect_valid = 1; redirect_pc = 8'hFE;
    step;
    redirect_valid = 0;
    push(8'hFE, 16'h10FE); push(8'hFF, 16'h10FF);
    step(2);
    chk("wrap_irpc_ff", ir_pc, 8'hFF);
    chk("wrap_pc", pc_out, 8'h00);
    step;
    ir_ready = 0;
    chk("wrap_irpc_00", ir_pc, 8'h00);
    chk("wrap_ir", ir, 16'h1000);
    chk("wrap_cnt", fetch_count, 13);

    // Reset while stalled with a valid word
    step;
    chk("pre_rst_vld", ir_valid, 1);
    chk("sb_left", sb_q.size(), 0);
    rst = 1;
    step;
    rst = 0;
    chk("mrst_vld", ir_valid, 0);
    chk("mrst_ir", ir, 0);
    chk("mrst_pc", pc_out, RESET_PC);
    chk("mrst_cnt", fetch_count, 0);
    chk("mrst_state", dut.state, ST_IDLE);
    step(2);
    chk("mrst_idle_vld", ir_valid, 0);
    chk("mrst_idle_cnt", fetch_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
